// File: rtl/imem_loader_if.sv
// Loader-side bus: host stream (start/len/data/valid) in, memory write port,
// CPU reset and status out.
//   slave  : the loader (drives ready/we/waddr/wdata/cpu_rst/busy/done/err/checksum)
//   master : the host/bench (drives start/len/data/valid)
interface imem_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              start_i;
  logic [ADDR_W:0]   len_i;
  logic [31:0]       data_i;
  logic              valid_i;
  logic              ready_o;
  logic              we_o;
  logic [31:0]       waddr_o;
  logic [31:0]       wdata_o;
  logic              cpu_rst_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;
  logic [31:0]       checksum_o;

  modport slave (
    input  start_i, len_i, data_i, valid_i,
    output ready_o, we_o, waddr_o, wdata_o, cpu_rst_o, busy_o, done_o, err_o, checksum_o
  );

  modport master (
    output start_i, len_i, data_i, valid_i,
    input  ready_o, we_o, waddr_o, wdata_o, cpu_rst_o, busy_o, done_o, err_o, checksum_o
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time program loader: streams 32-bit words into the instruction memory
// write port at consecutive word addresses, holds the CPU in reset until the
// image is complete, and keeps a running 32-bit checksum of the image.
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - synchronous active-high reset
//   bus    - imem_if.slave: start/len/data/valid in; ready, write port,
//            cpu_rst, busy, done, err, checksum out (all registered)
module imem_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic   clk_i,
  input  logic   rst_i,
  imem_if.slave  bus
);

  localparam int unsigned CW = ADDR_W + 1;
  localparam logic [CW-1:0] CAP = CW'(1) << ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_RUN} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   len_q, len_d;
  logic [31:0]     csum_q, csum_d;
  logic [31:0]     waddr_q, waddr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            err_q, err_d;
  logic            we_q, we_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            cpu_rst_q, cpu_rst_d;

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      csum_q    <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      we_q      <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cpu_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      csum_q    <= csum_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      we_q      <= we_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cpu_rst_q <= cpu_rst_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    csum_d  = csum_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    we_d    = 1'b0;

    unique case (state_q)
      S_IDLE, S_RUN: begin
        if (bus.start_i) begin
          if (bus.len_i > CAP) begin
            // Oversized image: flag it and keep the CPU parked in reset
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            err_d   = 1'b0;
            len_d   = bus.len_i;
            cnt_d   = '0;
            csum_d  = '0;
            state_d = (bus.len_i == '0) ? S_FLUSH : S_LOAD;
          end
        end
      end
      S_LOAD: begin
        // ready_q is high exactly while in LOAD
        if (bus.valid_i && ready_q) begin
          we_d    = 1'b1;
          waddr_d = 32'(cnt_q) << 2;
          wdata_d = bus.data_i;
          csum_d  = csum_q + bus.data_i;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == len_q - CW'(1)) state_d = S_FLUSH;
        end
      end
      S_FLUSH: state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered images of the next state
    ready_d   = (state_d == S_LOAD);
    busy_d    = (state_d == S_LOAD) || (state_d == S_FLUSH);
    done_d    = (state_d == S_RUN);
    cpu_rst_d = (state_d != S_RUN);
  end

  assign bus.ready_o    = ready_q;
  assign bus.we_o       = we_q;
  assign bus.waddr_o    = waddr_q;
  assign bus.wdata_o    = wdata_q;
  assign bus.cpu_rst_o  = cpu_rst_q;
  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
  assign bus.err_o      = err_q;
  assign bus.checksum_o = csum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader (ADDR_W = 8). Expected writes are the
// model image placed at 0,4,8,...; expected checksum is the modular sum of
// the image.
module tb_imem_loader;

  localparam int unsigned AW = 8;
  localparam int unsigned LW = AW + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_if #(.ADDR_W(AW)) bus ();
  imem_loader #(.ADDR_W(AW)) u_dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] exp_words[$];
  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];
  int          wq_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every write the DUT issues
  always @(negedge clk) begin
    if (bus.we_o === 1'b1) begin
      wq_addr.push_back(bus.waddr_o);
      wq_data.push_back(bus.wdata_o);
      wq_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_writes();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
  endtask

  function automatic logic [31:0] model_sum();
    logic [31:0] s = '0;
    foreach (exp_words[i]) s = s + exp_words[i];
    return s;
  endfunction

  task automatic fill_words(input int n);
    exp_words.delete();
    for (int i = 0; i < n; i++) exp_words.push_back($urandom);
  endtask

  task automatic issue_start(input int len);
    bus.start_i = 1'b1;
    bus.len_i   = LW'(len);
    tick();
    bus.start_i = 1'b0;
    bus.len_i   = LW'($urandom);
  endtask

  // Feed exp_words until 'target' beats are accepted; returns right after the
  // edge that takes the last beat. Valid is dropped with probability gap_pct%.
  task automatic drive_load(input int target, input int gap_pct, output int accepted);
    int idx = 0;
    int budget = target * 20 + 50;
    bit v;
    while (idx < target && budget > 0) begin
      v = ($urandom_range(99) >= gap_pct);
      bus.valid_i = v;
      bus.data_i  = v ? exp_words[idx] : $urandom;
      if (v && bus.ready_o === 1'b1) idx++;
      tick();
      budget--;
    end
    bus.valid_i = 1'b0;
    n_checks++;
    if (idx != target) begin
      n_fail++;
      $display("FAIL load_timeout: accepted %0d beats, required %0d", idx, target);
    end
    accepted = idx;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.valid_i = 1'b1;
    bus.data_i  = 32'hDEAD_BEEF;
    tick();
    tick();
    n_checks++;
    if ({bus.cpu_rst_o, bus.ready_o, bus.we_o, bus.busy_o, bus.done_o, bus.err_o} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 100000",
               {bus.cpu_rst_o, bus.ready_o, bus.we_o, bus.busy_o, bus.done_o, bus.err_o});
    end
    n_checks++;
    if ({bus.waddr_o, bus.wdata_o, bus.checksum_o} !== 96'd0) begin
      n_fail++;
      $display("FAIL reset_buses: got %h %h %h required 0", bus.waddr_o, bus.wdata_o, bus.checksum_o);
    end
    rst = 1'b0;
    tick();
    tick();
    n_checks++;
    if (bus.ready_o !== 1'b0 || wq_addr.size() != 0) begin
      n_fail++;
      $display("FAIL idle_valid: ready %b writes %0d, required 0 0", bus.ready_o, wq_addr.size());
    end
    bus.valid_i = 1'b0;
  endtask

  task automatic test_three_word();
    int acc;
    exp_words = '{32'h2008_0005, 32'h2009_0003, 32'h0109_5020};
    clear_writes();
    issue_start(3);
    n_checks++;
    if (bus.ready_o !== 1'b1 || bus.busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL start_latency: ready %b busy %b required 1 1", bus.ready_o, bus.busy_o);
    end
    drive_load(3, 0, acc);
    n_checks++;
    if ({bus.we_o, bus.ready_o, bus.busy_o, bus.cpu_rst_o} !== 4'b1011 || bus.waddr_o !== 32'h8) begin
      n_fail++;
      $display("FAIL last_beat: we/ready/busy/cpu_rst %b addr %h required 1011 8",
               {bus.we_o, bus.ready_o, bus.busy_o, bus.cpu_rst_o}, bus.waddr_o);
    end
    tick();
    n_checks++;
    if (bus.cpu_rst_o !== 1'b0 || bus.done_o !== 1'b1 || bus.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL release: cpu_rst %b done %b busy %b required 0 1 0",
               bus.cpu_rst_o, bus.done_o, bus.busy_o);
    end
    tick();
    n_checks++;
    if (wq_addr.size() != 3) begin
      n_fail++;
      $display("FAIL three_count: got %0d writes required 3", wq_addr.size());
    end else begin
      foreach (exp_words[i]) begin
        n_checks++;
        if (wq_addr[i] !== 32'(i * 4) || wq_data[i] !== exp_words[i]) begin
          n_fail++;
          $display("FAIL three_write%0d: got %h@%h required %h@%h", i, wq_data[i], wq_addr[i],
                   exp_words[i], 32'(i * 4));
        end
      end
      n_checks++;
      if (wq_cyc[2] - wq_cyc[0] != 2) begin
        n_fail++;
        $display("FAIL three_consecutive: span %0d cycles required 2", wq_cyc[2] - wq_cyc[0]);
      end
    end
    n_checks++;
    if (bus.checksum_o !== model_sum()) begin
      n_fail++;
      $display("FAIL three_checksum: got %h required %h", bus.checksum_o, model_sum());
    end
  endtask

  task automatic test_gapped();
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    fill_words(2);
    clear_writes();
    issue_start(2);
    for (int i = 0, k = 0; i < 4; i++) begin
      bus.valid_i = pat[i];
      bus.data_i  = pat[i] ? exp_words[k] : $urandom;
      if (pat[i]) k++;
      tick();
    end
    bus.valid_i = 1'b0;
    tick();
    tick();
    n_checks++;
    if (wq_addr.size() != 2) begin
      n_fail++;
      $display("FAIL gap_count: got %0d writes required 2", wq_addr.size());
    end else begin
      foreach (exp_words[i]) begin
        n_checks++;
        if (wq_addr[i] !== 32'(i * 4) || wq_data[i] !== exp_words[i]) begin
          n_fail++;
          $display("FAIL gap_write%0d: got %h@%h required %h@%h", i, wq_data[i], wq_addr[i],
                   exp_words[i], 32'(i * 4));
        end
      end
    end
    n_checks++;
    if (bus.checksum_o !== model_sum() || bus.done_o !== 1'b1) begin
      n_fail++;
      $display("FAIL gap_end: checksum %h done %b required %h 1", bus.checksum_o, bus.done_o, model_sum());
    end
  endtask

  task automatic test_full_capacity();
    int acc;
    fill_words(1 << AW);
    clear_writes();
    issue_start(1 << AW);
    drive_load(1 << AW, 0, acc);
    n_checks++;
    if (bus.we_o !== 1'b1 || bus.waddr_o !== 32'h3FC || bus.busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL full_last: we %b addr %h busy %b required 1 3fc 1", bus.we_o, bus.waddr_o, bus.busy_o);
    end
    tick();
    n_checks++;
    if (bus.done_o !== 1'b1 || bus.cpu_rst_o !== 1'b0) begin
      n_fail++;
      $display("FAIL full_run: done %b cpu_rst %b required 1 0", bus.done_o, bus.cpu_rst_o);
    end
    tick();
    n_checks++;
    if (wq_addr.size() != (1 << AW)) begin
      n_fail++;
      $display("FAIL full_count: got %0d writes required %0d", wq_addr.size(), 1 << AW);
    end else begin
      foreach (exp_words[i]) begin
        n_checks++;
        if (wq_addr[i] !== 32'(i * 4) || wq_data[i] !== exp_words[i]) begin
          n_fail++;
          $display("FAIL full_write%0d: got %h@%h required %h@%h", i, wq_data[i], wq_addr[i],
                   exp_words[i], 32'(i * 4));
        end
      end
    end
    n_checks++;
    if (bus.checksum_o !== model_sum()) begin
      n_fail++;
      $display("FAIL full_checksum: got %h required %h", bus.checksum_o, model_sum());
    end
  endtask

  task automatic test_len_error();
    logic [31:0] prev_sum;
    prev_sum = bus.checksum_o;
    clear_writes();
    // Oversized start while running drops back to IDLE
    issue_start((1 << AW) + 1);
    n_checks++;
    if ({bus.err_o, bus.done_o, bus.cpu_rst_o, bus.busy_o, bus.ready_o} !== 5'b10100) begin
      n_fail++;
      $display("FAIL err_from_run: err/done/cpu_rst/busy/ready %b required 10100",
               {bus.err_o, bus.done_o, bus.cpu_rst_o, bus.busy_o, bus.ready_o});
    end
    // Oversized start while idle stays in IDLE
    issue_start(511);
    tick();
    tick();
    n_checks++;
    if ({bus.err_o, bus.busy_o, bus.ready_o, bus.done_o} !== 4'b1000 || wq_addr.size() != 0
        || bus.checksum_o !== prev_sum) begin
      n_fail++;
      $display("FAIL err_idle: err/busy/ready/done %b writes %0d csum %h required 1000 0 %h",
               {bus.err_o, bus.busy_o, bus.ready_o, bus.done_o}, wq_addr.size(), bus.checksum_o, prev_sum);
    end
    issue_start(0);
    n_checks++;
    if (bus.err_o !== 1'b0 || bus.busy_o !== 1'b1 || bus.ready_o !== 1'b0 || bus.checksum_o !== 32'd0) begin
      n_fail++;
      $display("FAIL zero_flush: err %b busy %b ready %b csum %h required 0 1 0 0",
               bus.err_o, bus.busy_o, bus.ready_o, bus.checksum_o);
    end
    tick();
    n_checks++;
    if (bus.done_o !== 1'b1 || bus.cpu_rst_o !== 1'b0 || wq_addr.size() != 0) begin
      n_fail++;
      $display("FAIL zero_run: done %b cpu_rst %b writes %0d required 1 0 0",
               bus.done_o, bus.cpu_rst_o, wq_addr.size());
    end
  endtask

  task automatic test_reload();
    int acc;
    fill_words(1);
    clear_writes();
    issue_start(1);
    n_checks++;
    if (bus.cpu_rst_o !== 1'b1 || bus.ready_o !== 1'b1 || bus.done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reload_enter: cpu_rst %b ready %b done %b required 1 1 0",
               bus.cpu_rst_o, bus.ready_o, bus.done_o);
    end
    drive_load(1, 0, acc);
    tick();
    tick();
    n_checks++;
    if (wq_addr.size() != 1 || wq_addr[0] !== 32'd0 || wq_data[0] !== exp_words[0]) begin
      n_fail++;
      $display("FAIL reload_write: %0d writes, first %h@%h required 1 write %h@0",
               wq_addr.size(), wq_data[0], wq_addr[0], exp_words[0]);
    end
    n_checks++;
    if (bus.checksum_o !== exp_words[0] || bus.done_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reload_checksum: got %h done %b required %h 1", bus.checksum_o, bus.done_o, exp_words[0]);
    end
  endtask

  task automatic test_rst_midload();
    int acc;
    fill_words(5);
    issue_start(5);
    drive_load(2, 0, acc);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({bus.busy_o, bus.ready_o, bus.we_o, bus.done_o, bus.cpu_rst_o} !== 5'b00001
        || bus.checksum_o !== 32'd0) begin
      n_fail++;
      $display("FAIL midrst_state: busy/ready/we/done/cpu_rst %b csum %h required 00001 0",
               {bus.busy_o, bus.ready_o, bus.we_o, bus.done_o, bus.cpu_rst_o}, bus.checksum_o);
    end
    fill_words(3);
    clear_writes();
    issue_start(3);
    drive_load(3, 25, acc);
    tick();
    tick();
    n_checks++;
    if (wq_addr.size() != 3) begin
      n_fail++;
      $display("FAIL midrst_count: got %0d writes required 3", wq_addr.size());
    end else begin
      foreach (exp_words[i]) begin
        n_checks++;
        if (wq_addr[i] !== 32'(i * 4) || wq_data[i] !== exp_words[i]) begin
          n_fail++;
          $display("FAIL midrst_write%0d: got %h@%h required %h@%h", i, wq_data[i], wq_addr[i],
                   exp_words[i], 32'(i * 4));
        end
      end
    end
    n_checks++;
    if (bus.checksum_o !== model_sum()) begin
      n_fail++;
      $display("FAIL midrst_checksum: got %h required %h", bus.checksum_o, model_sum());
    end
  endtask

  task automatic test_random();
    int acc;
    int n;
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(24, 1);
      fill_words(n);
      clear_writes();
      issue_start(n);
      drive_load(n, 40, acc);
      // Start pulses while loading/flushing must be ignored
      bus.start_i = 1'b1;
      bus.len_i   = LW'(0);
      tick();
      bus.start_i = 1'b0;
      tick();
      tick();
      n_checks++;
      if (wq_addr.size() != n || bus.done_o !== 1'b1) begin
        n_fail++;
        $display("FAIL rand%0d_count: %0d writes done %b required %0d 1", r, wq_addr.size(), bus.done_o, n);
      end else begin
        foreach (exp_words[i]) begin
          n_checks++;
          if (wq_addr[i] !== 32'(i * 4) || wq_data[i] !== exp_words[i]) begin
            n_fail++;
            $display("FAIL rand%0d_write%0d: got %h@%h required %h@%h", r, i, wq_data[i], wq_addr[i],
                     exp_words[i], 32'(i * 4));
          end
        end
      end
      n_checks++;
      if (bus.checksum_o !== model_sum()) begin
        n_fail++;
        $display("FAIL rand%0d_checksum: got %h required %h", r, bus.checksum_o, model_sum());
      end
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.start_i = 1'b0;
    bus.len_i   = '0;
    bus.data_i  = '0;
    bus.valid_i = 1'b0;
    test_reset();
    test_three_word();
    test_gapped();
    test_full_capacity();
    test_len_error();
    test_reload();
    test_rst_midload();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
